// File: rtl/fifo_uart_tx.sv
// Serial transmitter that pops words from an upstream FIFO and sends them as
// start bit, data LSB first, optional even parity, stop bit on a registered TX pin.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

    state_t                  state_q, state_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    parity_q, parity_d;
    logic                    tx_q, tx_d;
    logic                    baud_last;

    assign baud_last  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign fifo_rd_en = (state_q == IDLE) && enable && !fifo_empty && !rst;
    assign busy       = (state_q != IDLE) || fifo_rd_en;
    assign tx_done    = (state_q == STOP) && baud_last;
    assign tx         = tx_q;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (fifo_rd_en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d  = fifo_dout;
                parity_d = ^fifo_dout;
                baud_d   = '0;
                bit_d    = '0;
                state_d  = START;
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The pin level is derived from the next state so tx_q lines up with state_q.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (plain, even parity, one clock per bit)
// checked cycle by cycle against an expected-waveform model built from each popped word.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [2:0] empty_v;
    logic [7:0] dout_a [3];
    logic [2:0] rd_v, tx_v, busy_v, done_v;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            fifo_uart_tx #(
                .DATA_WIDTH  (8),
                .CLKS_PER_BIT((gi == 2) ? 1 : 4),
                .PARITY_EN   ((gi == 1) ? 1 : 0)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .enable    (enable),
                .fifo_empty(empty_v[gi]),
                .fifo_dout (dout_a[gi]),
                .fifo_rd_en(rd_v[gi]),
                .tx        (tx_v[gi]),
                .busy      (busy_v[gi]),
                .tx_done   (done_v[gi])
            );
        end
    endgenerate

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         nbits;
        logic [11:0] bits;   // bit j = j-th serial bit sent
        int         len;
    } vec_t;

    vec_t        vecs [4];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        chk_en = 1'b0;
    logic [7:0]  fifo_q [3][$];
    logic [2:0]  exp_q [3][$];   // {tx, busy, tx_done}
    logic        samples [3][$];
    int          pop_cnt [3];
    logic        in_frame [3];
    logic        done_seen [3];
    int          done_cyc [3];
    int          last_gap [3];
    int          last_len [3];
    logic [11:0] last_bits [3];

    function automatic int cpb_f(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic bit par_f(input int i);
        return (i == 1);
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic push_word(input int i, input logic [7:0] b);
        fifo_q[i].push_back(b);
        empty_v[i] = 1'b0;
    endtask

    // Expected waveform: one LOAD cycle, then each frame bit held for CLKS_PER_BIT cycles.
    task automatic push_frame(input int i, input logic [7:0] b);
        logic fb [$];
        fb.push_back(1'b0);
        for (int k = 0; k < 8; k++) fb.push_back(b[k]);
        if (par_f(i)) fb.push_back(^b);
        fb.push_back(1'b1);
        exp_q[i].push_back(3'b110);
        for (int k = 0; k < fb.size(); k++)
            for (int r = 0; r < cpb_f(i); r++)
                exp_q[i].push_back({fb[k], 1'b1, (k == fb.size() - 1) && (r == cpb_f(i) - 1)});
    endtask

    task automatic cycle();
        logic [2:0] pop;
        logic       exp_rd;
        logic [2:0] e;
        logic [3:0] got, want;
        int         nb;
        @(negedge clk);
        pop = '0;
        for (int i = 0; i < 3; i++) begin
            exp_rd = !rst && enable && (fifo_q[i].size() != 0) && (exp_q[i].size() == 0);
            e      = (exp_q[i].size() != 0) ? exp_q[i][0] : {1'b1, exp_rd, 1'b0};
            want   = {exp_rd, e};
            got    = {rd_v[i], tx_v[i], busy_v[i], done_v[i]};
            if (chk_en) begin
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL model[%0d] cyc %0d: {rd_en,tx,busy,done} got %b required %b",
                             i, cyc, got, want);
                end
            end
            pop[i] = exp_rd;
            if (rd_v[i] === 1'b1) pop_cnt[i]++;
            if (rst) begin
                in_frame[i] = 1'b0;
            end else begin
                if (!in_frame[i] && tx_v[i] === 1'b0) begin
                    in_frame[i] = 1'b1;
                    samples[i].delete();
                    last_gap[i] = cyc - done_cyc[i] - 1;
                end
                if (in_frame[i]) begin
                    samples[i].push_back(tx_v[i]);
                    if (done_v[i] === 1'b1) begin
                        in_frame[i]  = 1'b0;
                        done_seen[i] = 1'b1;
                        done_cyc[i]  = cyc;
                        last_len[i]  = samples[i].size();
                        nb = samples[i].size() / cpb_f(i);
                        last_bits[i] = '0;
                        for (int j = 0; j < nb && j < 12; j++)
                            last_bits[i][j] = samples[i][j * cpb_f(i) + cpb_f(i) / 2];
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                exp_q[i].delete();
            end else begin
                if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
                if (pop[i]) begin
                    dout_a[i] = fifo_q[i].pop_front();
                    push_frame(i, dout_a[i]);
                end
            end
            empty_v[i] = (fifo_q[i].size() == 0);
        end
    endtask

    task automatic wait_done(input int i, input int budget, input string name);
        int n;
        n = 0;
        done_seen[i] = 1'b0;
        while (!done_seen[i] && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (!done_seen[i]) begin
            errors++;
            $display("FAIL %s: tx_done not seen, waited %0d cycles, required within %0d", name, n, budget);
        end
    endtask

    initial begin
        int pc;
        int n;
        int inst;

        vecs[0] = '{inst: 0, data: 8'hA5, nbits: 10, bits: 12'b00_1101001010, len: 40};
        vecs[1] = '{inst: 1, data: 8'hA5, nbits: 11, bits: 12'b0_10101001010, len: 44};
        vecs[2] = '{inst: 1, data: 8'h07, nbits: 11, bits: 12'b0_11000001110, len: 44};
        vecs[3] = '{inst: 2, data: 8'hFF, nbits: 10, bits: 12'b00_1111111110, len: 10};

        for (int i = 0; i < 3; i++) begin
            pop_cnt[i] = 0; in_frame[i] = 1'b0; done_seen[i] = 1'b0;
            done_cyc[i] = 0; last_gap[i] = 0; last_len[i] = 0; last_bits[i] = '0;
            dout_a[i] = 8'h00;
        end
        rst = 1'b1;
        enable = 1'b0;
        empty_v = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_tx[%0d]", i), int'(tx_v[i]), 1);
            chk($sformatf("reset_busy[%0d]", i), int'(busy_v[i]), 0);
            chk($sformatf("reset_done[%0d]", i), int'(done_v[i]), 0);
            chk($sformatf("reset_rd_en[%0d]", i), int'(rd_v[i]), 0);
        end
        cycle();
        rst = 1'b0;
        cycle();

        // Idle with an empty FIFO: nothing may be popped
        enable = 1'b1;
        pc = pop_cnt[0] + pop_cnt[1] + pop_cnt[2];
        repeat (20) cycle();
        chk("empty_no_pop", pop_cnt[0] + pop_cnt[1] + pop_cnt[2] - pc, 0);

        // Single frames from the vector table
        for (int v = 0; v < 4; v++) begin
            inst = vecs[v].inst;
            pc = pop_cnt[inst];
            push_word(inst, vecs[v].data);
            wait_done(inst, 200, $sformatf("vec%0d_done", v));
            chk($sformatf("vec%0d_len", v), last_len[inst], vecs[v].len);
            chk($sformatf("vec%0d_bits", v), int'(last_bits[inst]), int'(vecs[v].bits));
            chk($sformatf("vec%0d_pops", v), pop_cnt[inst] - pc, 1);
            $display("vec%0d inst=%0d data=%h len=%0d bits=%b", v, inst, vecs[v].data, last_len[inst], last_bits[inst]);
        end

        // Back-to-back frames with a 2-cycle idle gap
        enable = 1'b0;
        push_word(0, 8'h11);
        push_word(0, 8'h22);
        push_word(0, 8'h33);
        pc = pop_cnt[0];
        enable = 1'b1;
        wait_done(0, 200, "b2b_frame1");
        wait_done(0, 200, "b2b_frame2");
        chk("b2b_gap2", last_gap[0], 2);
        wait_done(0, 200, "b2b_frame3");
        chk("b2b_gap3", last_gap[0], 2);
        chk("b2b_bits3", int'(last_bits[0]), int'(12'b00_1001100110));
        repeat (20) cycle();
        chk("b2b_pops", pop_cnt[0] - pc, 3);
        chk("b2b_fifo_empty", fifo_q[0].size(), 0);
        $display("b2b pops=%0d gap=%0d", pop_cnt[0] - pc, last_gap[0]);

        // Enable dropped mid-frame: frame completes, second word stays queued
        enable = 1'b0;
        push_word(0, 8'h81);
        push_word(0, 8'h42);
        pc = pop_cnt[0];
        enable = 1'b1;
        repeat (8) cycle();
        enable = 1'b0;
        wait_done(0, 200, "endrop_done");
        chk("endrop_bits", int'(last_bits[0]), int'(12'b00_1100000010));
        repeat (30) cycle();
        chk("endrop_pops", pop_cnt[0] - pc, 1);
        chk("endrop_left", fifo_q[0].size(), 1);
        enable = 1'b1;
        wait_done(0, 200, "endrop_resume");
        chk("endrop_resume_bits", int'(last_bits[0]), int'(12'b00_1010000100));
        $display("enable-drop pops=%0d", pop_cnt[0] - pc);

        // Reset during the DATA state of 0x3C, then a clean 0x5A frame
        push_word(0, 8'h3C);
        repeat (14) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rstmid_tx", int'(tx_v[0]), 1);
        chk("rstmid_busy", int'(busy_v[0]), 0);
        push_word(0, 8'h5A);
        wait_done(0, 200, "rstmid_5a_done");
        chk("rstmid_5a_len", last_len[0], 40);
        chk("rstmid_5a_bits", int'(last_bits[0]), int'(12'b00_1010110100));
        $display("reset-mid-frame recovery len=%0d bits=%b", last_len[0], last_bits[0]);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                inst = $urandom_range(0, 2);
                if (fifo_q[inst].size() < 4) push_word(inst, 8'($urandom));
            end
            enable = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;
        enable = 1'b1;
        n = 0;
        while ((fifo_q[0].size() + fifo_q[1].size() + fifo_q[2].size() +
                exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 3000) begin
            cycle();
            n++;
        end
        chk("random_drained", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
        $display("random phase drained after %0d cycles", n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
